lock_queue_arbiter: RTL and testbench



---
 rtl/lock_queue_arbiter_pkg.sv | 24 ++
 rtl/lock_queue_arbiter_fifo.sv | 60 ++++++
 rtl/lock_queue_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_lock_queue_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lock_queue_arbiter_pkg.sv
// lock_queue_arbiter_pkg
// Shared command/ack encodings and field positions for the lock queue arbiter.
// Command word layout on inStream_TDATA:
//   [CMD_TYPE_H:CMD_TYPE_L] command code
//   [LOCK_ID_H:LOCK_ID_L]   lock id
// Ack word on outStream_TDATA is {56'd0, ack_code}.
package lock_queue_arbiter_pkg;

    localparam int CMD_TYPE_L   = 0;
    localparam int CMD_TYPE_H   = 7;
    localparam int LOCK_ID_L    = 8;
    localparam int LOCK_ID_H    = 15;
    localparam int LOCK_ID_BITS = LOCK_ID_H - LOCK_ID_L + 1;

    localparam logic [7:0] CMD_LOCK_CODE   = 8'h04;
    localparam logic [7:0] CMD_UNLOCK_CODE = 8'h05;
    localparam logic [7:0] ACK_OK_CODE     = 8'h01;
    localparam logic [7:0] ACK_REJECT_CODE = 8'h00;

    function automatic logic [63:0] ack_word(input logic [7:0] code);
        return {56'd0, code};
    endfunction

endpackage

// File: rtl/lock_queue_arbiter_fifo.sv
// lock_waiter_fifo
// Circular FIFO holding the accelerator ids waiting on one lock.
// Pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
// Ports:
//   clk, rst        clock, synchronous active-high reset (empties the FIFO)
//   push, push_data enqueue an id (caller guarantees not full)
//   pop             dequeue the head (caller guarantees not empty)
//   head            id at the read pointer
//   count           number of stored ids, 0..DEPTH
module lock_waiter_fifo #(
    parameter int  DEPTH = 16,
    parameter int  WIDTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [PTR_W:0]   count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= bump(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/lock_queue_arbiter.sv
// lock_queue_arbiter
// Serialises NUM_LOCKS named locks between MAX_ACCS accelerators. Contended
// LOCKs queue per lock in FIFO order; a waiter is acked only when ownership
// is handed to it by an UNLOCK.
// Optional feature macro: LOCK_ARB_OWNER_CHECK_EN -- when defined, an UNLOCK
// from anyone other than the current owner is ignored.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   inStream_TDATA/TVALID/TID/TREADY    command stream (TID = issuing acc)
//   outStream_TDATA/TVALID/TREADY/TLAST/TDEST  ack stream (TDEST = target acc)
module lock_queue_arbiter
    import lock_queue_arbiter_pkg::*;
#(
    parameter int  MAX_ACCS  = 16,
    parameter int  NUM_LOCKS = 4,
    localparam int ACC_BITS  = $clog2(MAX_ACCS),
    localparam int LIDX_BITS = (NUM_LOCKS > 1) ? $clog2(NUM_LOCKS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [63:0]         inStream_TDATA,
    input  logic                inStream_TVALID,
    input  logic [ACC_BITS-1:0] inStream_TID,
    output logic                inStream_TREADY,
    output logic [63:0]         outStream_TDATA,
    output logic                outStream_TVALID,
    input  logic                outStream_TREADY,
    output logic                outStream_TLAST,
    output logic [ACC_BITS-1:0] outStream_TDEST
);

    typedef enum logic [1:0] {
        READ_HEADER,
        EXEC,
        SEND_ACK
    } arb_state_t;

    localparam logic [ACC_BITS:0] FULL_CNT = (ACC_BITS + 1)'(MAX_ACCS);

    arb_state_t                               state;
    logic                                     tready_q;
    logic                                     tvalid_q;
    logic [63:0]                              tdata_q;
    logic [ACC_BITS-1:0]                      tdest_q;

    logic [ACC_BITS-1:0]                      acc_q;
    logic [7:0]                               cmd_q;
    logic [LOCK_ID_BITS-1:0]                  lid_q;

    logic [NUM_LOCKS-1:0]                     owned;
    logic [NUM_LOCKS-1:0][ACC_BITS-1:0]       owner;

    logic [NUM_LOCKS-1:0]                     push_vec;
    logic [NUM_LOCKS-1:0]                     pop_vec;
    logic [ACC_BITS-1:0]                      head [NUM_LOCKS];
    logic [ACC_BITS:0]                        cnt  [NUM_LOCKS];

    logic [LIDX_BITS-1:0]                     lidx;
    logic                                     lid_ok;
    logic                                     owner_ok;
    logic                                     ack_en;
    logic [7:0]                               ack_code;
    logic [ACC_BITS-1:0]                      ack_dest;
    logic                                     grant_free;
    logic                                     rel_lock;
    logic                                     unused_tdata;

    assign lidx   = lid_q[LIDX_BITS-1:0];
    assign lid_ok = (32'(lid_q) < NUM_LOCKS);

`ifdef LOCK_ARB_OWNER_CHECK_EN
    assign owner_ok = (acc_q == owner[lidx]);
`else
    logic unused_owner;
    assign owner_ok     = 1'b1;
    assign unused_owner = ^owner;
`endif

    assign unused_tdata = ^inStream_TDATA[63:LOCK_ID_H+1];

    for (genvar g = 0; g < NUM_LOCKS; g++) begin : g_waiters
        lock_waiter_fifo #(
            .DEPTH(MAX_ACCS),
            .WIDTH(ACC_BITS)
        ) u_fifo (
            .clk      (clk),
            .rst      (rst),
            .push     (push_vec[g]),
            .push_data(acc_q),
            .pop      (pop_vec[g]),
            .head     (head[g]),
            .count    (cnt[g])
        );
    end

    // Decision for the command latched in EXEC; the FSM below only registers it.
    always_comb begin
        ack_en     = 1'b0;
        ack_code   = ACK_OK_CODE;
        ack_dest   = acc_q;
        grant_free = 1'b0;
        rel_lock   = 1'b0;
        push_vec   = '0;
        pop_vec    = '0;
        if (state == EXEC) begin
            if (!lid_ok) begin
                if (cmd_q == CMD_LOCK_CODE) begin
                    ack_en   = 1'b1;
                    ack_code = ACK_REJECT_CODE;
                end
            end else if (cmd_q == CMD_LOCK_CODE) begin
                if (!owned[lidx]) begin
                    grant_free = 1'b1;
                    ack_en     = 1'b1;
                end else if (cnt[lidx] == FULL_CNT) begin
                    ack_en   = 1'b1;
                    ack_code = ACK_REJECT_CODE;
                end else begin
                    push_vec[lidx] = 1'b1;
                end
            end else if (cmd_q == CMD_UNLOCK_CODE && owned[lidx] && owner_ok) begin
                if (cnt[lidx] == '0) begin
                    rel_lock = 1'b1;
                end else begin
                    // Hand-off: lock stays owned, the head waiter gets the ack.
                    pop_vec[lidx] = 1'b1;
                    ack_en        = 1'b1;
                    ack_dest      = head[lidx];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= READ_HEADER;
            tready_q <= 1'b0;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tdest_q  <= '0;
            acc_q    <= '0;
            cmd_q    <= '0;
            lid_q    <= '0;
            owned    <= '0;
            owner    <= '0;
        end else begin
            case (state)
                READ_HEADER: begin
                    // TREADY rises one cycle after entering, so the reset cycle stays quiet.
                    if (tready_q && inStream_TVALID) begin
                        acc_q    <= inStream_TID;
                        cmd_q    <= inStream_TDATA[CMD_TYPE_H:CMD_TYPE_L];
                        lid_q    <= inStream_TDATA[LOCK_ID_H:LOCK_ID_L];
                        tready_q <= 1'b0;
                        state    <= EXEC;
                    end else begin
                        tready_q <= 1'b1;
                    end
                end
                EXEC: begin
                    state    <= READ_HEADER;
                    tready_q <= 1'b1;
                    if (ack_en) begin
                        tvalid_q <= 1'b1;
                        tdata_q  <= ack_word(ack_code);
                        tdest_q  <= ack_dest;
                        tready_q <= 1'b0;
                        state    <= SEND_ACK;
                    end
                    if (grant_free) begin
                        owned[lidx] <= 1'b1;
                        owner[lidx] <= acc_q;
                    end
                    if (pop_vec != '0) begin
                        owner[lidx] <= head[lidx];
                    end
                    if (rel_lock) begin
                        owned[lidx] <= 1'b0;
                    end
                end
                SEND_ACK: begin
                    if (outStream_TREADY) begin
                        tvalid_q <= 1'b0;
                        tready_q <= 1'b1;
                        state    <= READ_HEADER;
                    end
                end
                default: begin
                    state    <= READ_HEADER;
                    tready_q <= 1'b0;
                    tvalid_q <= 1'b0;
                end
            endcase
        end
    end

    assign inStream_TREADY  = tready_q;
    assign outStream_TVALID = tvalid_q;
    assign outStream_TDATA  = tdata_q;
    assign outStream_TDEST  = tdest_q;
    assign outStream_TLAST  = 1'b1;

endmodule

// File: tb/tb_lock_queue_arbiter.sv
// tb_lock_queue_arbiter
// Scoreboard bench: the driver applies commands and a queue-based lock model
// pushes the expected acks; an independent monitor checks every ack the DUT
// presents, its latency, and its stability under back-pressure.
module tb_lock_queue_arbiter;
    import lock_queue_arbiter_pkg::*;

    localparam int NL = 4;
    localparam int MA = 16;

    logic        clk;
    logic        rst;
    logic [63:0] in_tdata;
    logic        in_tvalid;
    logic [3:0]  in_tid;
    logic        in_tready;
    logic [63:0] out_tdata;
    logic        out_tvalid;
    logic        out_tready;
    logic        out_tlast;
    logic [3:0]  out_tdest;

    lock_queue_arbiter #(.MAX_ACCS(MA), .NUM_LOCKS(NL)) dut (
        .clk             (clk),
        .rst             (rst),
        .inStream_TDATA  (in_tdata),
        .inStream_TVALID (in_tvalid),
        .inStream_TID    (in_tid),
        .inStream_TREADY (in_tready),
        .outStream_TDATA (out_tdata),
        .outStream_TVALID(out_tvalid),
        .outStream_TREADY(out_tready),
        .outStream_TLAST (out_tlast),
        .outStream_TDEST (out_tdest)
    );

    typedef struct {
        logic [63:0] data;
        logic [3:0]  dest;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   rdy_mode = 1;   // 0 random, 1 always ready, 2 stalled

    bit   m_owned[NL];
    int   m_owner[NL];
    int   m_wait[NL][$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        out_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0)      out_tready = ($urandom_range(0, 9) < 7);
            else if (rdy_mode == 1) out_tready = 1'b1;
            else                    out_tready = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void exp_push(input logic [7:0] code, input int dest, input int c);
        exp_t e;
        e.data = {56'd0, code};
        e.dest = dest[3:0];
        e.cyc  = c;
        exp_q.push_back(e);
    endfunction

    function automatic void model_clear();
        for (int l = 0; l < NL; l++) begin
            m_owned[l] = 1'b0;
            m_owner[l] = 0;
            m_wait[l].delete();
        end
    endfunction

    function automatic void model_cmd(input int acc, input logic [7:0] cmd, input int lid, input int c);
        bit may_unlock;
        if (lid >= NL) begin
            if (cmd == CMD_LOCK_CODE) exp_push(ACK_REJECT_CODE, acc, c);
            return;
        end
        if (cmd == CMD_LOCK_CODE) begin
            if (!m_owned[lid]) begin
                m_owned[lid] = 1'b1;
                m_owner[lid] = acc;
                exp_push(ACK_OK_CODE, acc, c);
            end else if (m_wait[lid].size() == MA) begin
                exp_push(ACK_REJECT_CODE, acc, c);
            end else begin
                m_wait[lid].push_back(acc);
            end
        end else if (cmd == CMD_UNLOCK_CODE) begin
`ifdef LOCK_ARB_OWNER_CHECK_EN
            may_unlock = (acc == m_owner[lid]);
`else
            may_unlock = 1'b1;
`endif
            if (m_owned[lid] && may_unlock) begin
                if (m_wait[lid].size() == 0) begin
                    m_owned[lid] = 1'b0;
                end else begin
                    m_owner[lid] = m_wait[lid].pop_front();
                    exp_push(ACK_OK_CODE, m_owner[lid], c);
                end
            end
        end
    endfunction

    function automatic int owned_by(input int acc);
        for (int l = 0; l < NL; l++)
            if (m_owned[l] && m_owner[l] == acc) return l;
        return -1;
    endfunction

    function automatic bit is_waiting(input int acc);
        for (int l = 0; l < NL; l++)
            foreach (m_wait[l][k])
                if (m_wait[l][k] == acc) return 1'b1;
        return 1'b0;
    endfunction

    // ---------------- driver ----------------
    task automatic send_cmd(input int acc, input logic [7:0] cmd, input int lid);
        logic [63:0] w;
        logic [7:0]  lid8;
        bit          done;
        int          acc_cyc;
        w        = '0;
        lid8     = lid[7:0];
        w[CMD_TYPE_H:CMD_TYPE_L] = cmd;
        w[LOCK_ID_H:LOCK_ID_L]   = lid8;
        @(posedge clk);
        #1;
        in_tdata  = w;
        in_tid    = acc[3:0];
        in_tvalid = 1'b1;
        done      = 1'b0;
        acc_cyc   = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (in_tready) begin
                acc_cyc = cyc;
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        in_tvalid = 1'b0;
        if (done) begin
            model_cmd(acc, cmd, lid, acc_cyc);
        end else begin
            checks++;
            errors++;
            $display("FAIL cmd_accept_timeout: acc %0d cmd %0h lid %0d never accepted", acc, cmd, lid);
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 600 && !ok; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_tvalid) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: %0d acks still pending, required 0", exp_q.size());
        end
    endtask

    task automatic drain_locks();
        for (int l = 0; l < NL; l++)
            for (int n = 0; n < MA + 2 && m_owned[l]; n++)
                send_cmd(m_owner[l], CMD_UNLOCK_CODE, l);
        wait_idle();
    endtask

    task automatic do_reset();
        in_tvalid = 1'b0;
        rst       = 1'b1;
        exp_q.delete();
        model_clear();
        @(posedge clk);
        #1;
        chk("reset_tvalid", 64'(out_tvalid), 64'd0);
        chk("reset_tdata",  out_tdata, 64'd0);
        chk("reset_tdest",  64'(out_tdest), 64'd0);
        chk("reset_in_tready", 64'(in_tready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t        e;
        bit          pv;
        bit          prdy;
        logic [63:0] pdata;
        logic [3:0]  pdest;
        pv = 1'b0;
        prdy = 1'b0;
        pdata = '0;
        pdest = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pv = 1'b0;
            end else begin
                if (out_tvalid) begin
                    chk("in_tready_during_ack", 64'(in_tready), 64'd0);
                    if (!pv && exp_q.size() > 0)
                        chk("ack_latency", 64'(cyc), 64'(exp_q[0].cyc + 2));
                    if (pv && !prdy) begin
                        chk("stall_tdata_stable", out_tdata, pdata);
                        chk("stall_tdest_stable", 64'(out_tdest), 64'(pdest));
                    end
                    if (out_tready) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_ack: tdest %0d tdata %0h, no ack expected", out_tdest, out_tdata);
                        end else begin
                            e = exp_q.pop_front();
                            chk("ack_tdata", out_tdata, e.data);
                            chk("ack_tdest", 64'(out_tdest), 64'(e.dest));
                            chk("ack_tlast", 64'(out_tlast), 64'd1);
                        end
                    end
                end
                pv    = out_tvalid;
                prdy  = out_tready;
                pdata = out_tdata;
                pdest = out_tdest;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int acc;
        int lid;
        int l;
        int r;
        bit seen;
        in_tdata  = '0;
        in_tvalid = 1'b0;
        in_tid    = '0;
        rst       = 1'b1;
        model_clear();
        do_reset();

        // uncontended grant
        send_cmd(3, CMD_LOCK_CODE, 1);
        wait_idle();

        // FIFO hand-off order 5 then 7, then free
        send_cmd(5, CMD_LOCK_CODE, 1);
        send_cmd(7, CMD_LOCK_CODE, 1);
        send_cmd(3, CMD_UNLOCK_CODE, 1);
        send_cmd(5, CMD_UNLOCK_CODE, 1);
        send_cmd(7, CMD_UNLOCK_CODE, 1);
        send_cmd(8, CMD_LOCK_CODE, 1);
        send_cmd(8, CMD_UNLOCK_CODE, 1);
        wait_idle();

        // independent locks
        send_cmd(2, CMD_LOCK_CODE, 0);
        send_cmd(4, CMD_LOCK_CODE, 2);
        drain_locks();

        // back-pressure on the ack
        rdy_mode = 2;
        send_cmd(6, CMD_LOCK_CODE, 3);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = out_tvalid;
        end
        chk("stall_ack_presented", 64'(seen), 64'd1);
        repeat (10) @(negedge clk);
        rdy_mode = 1;
        wait_idle();
        drain_locks();

        // out-of-range id and full waiter FIFO
        send_cmd(1, CMD_LOCK_CODE, NL);
        send_cmd(1, CMD_UNLOCK_CODE, NL);
        send_cmd(0, CMD_LOCK_CODE, 0);
        for (int a = 0; a < MA; a++) send_cmd(a, CMD_LOCK_CODE, 0);
        send_cmd(1, CMD_LOCK_CODE, 0);
        drain_locks();

        // UNLOCK from a non-owner with a waiter queued
        send_cmd(1, CMD_LOCK_CODE, 1);
        send_cmd(4, CMD_LOCK_CODE, 1);
        send_cmd(9, CMD_UNLOCK_CODE, 1);
        wait_idle();
        drain_locks();

        // reset with a waiter queued and an ack stalled
        send_cmd(1, CMD_LOCK_CODE, 2);
        send_cmd(5, CMD_LOCK_CODE, 2);
        rdy_mode = 2;
        send_cmd(6, CMD_LOCK_CODE, 3);
        repeat (4) @(negedge clk);
        do_reset();
        rdy_mode = 1;
        @(negedge clk);
        chk("post_reset_tvalid", 64'(out_tvalid), 64'd0);
        send_cmd(5, CMD_LOCK_CODE, 2);
        send_cmd(6, CMD_LOCK_CODE, 3);
        wait_idle();
        drain_locks();

        // randomized traffic
        rdy_mode = 0;
        for (int n = 0; n < 300; n++) begin
            acc = $urandom_range(0, MA - 1);
            lid = $urandom_range(0, NL);
            r   = $urandom_range(0, 9);
            l   = owned_by(acc);
            if (r == 0)
                send_cmd(acc, 8'h09, lid);
            else if (l >= 0 && r < 8)
                send_cmd(acc, CMD_UNLOCK_CODE, l);
            else if (!is_waiting(acc) && l < 0 && r < 8)
                send_cmd(acc, CMD_LOCK_CODE, lid);
            else
                send_cmd(acc, CMD_UNLOCK_CODE, lid);
        end
        rdy_mode = 1;
        wait_idle();
        drain_locks();
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
